// File: rtl/deser8_way.sv
// deser8_way: serial-to-parallel collector with valid/ready on both sides and an OR-reduction flag.
// Optional macro DESER8_WAY_PARITY_EN appends an even-parity bit per word and adds par_err_o.
module deser8_way #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [WIDTH-1:0]             out_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         any_o,
`ifdef DESER8_WAY_PARITY_EN
    output logic                         par_err_o,
`endif
    output logic [$clog2(WIDTH+1)-1:0]   cnt_o
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Handshakes: a bit moves when in_valid_i && in_ready_o; a word moves when
    // out_valid_o && out_ready_i. in_ready_o never depends on in_valid_i.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        PARITY  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [WIDTH-1:0]   out_q,   out_d;
    logic               any_q,   any_d;
`ifdef DESER8_WAY_PARITY_EN
    logic               par_q,   par_d;
`endif

    logic [WIDTH-1:0]   shift_src;
    logic [WIDTH-1:0]   shifted;

    // In HOLD the shift register is empty, so a bit taken there starts a fresh word.
    assign shift_src = (state_q == HOLD) ? '0 : shreg_q;
    assign shifted   = (LSB_FIRST != 0) ? {in_i, shift_src[WIDTH-1:1]}
                                        : {shift_src[WIDTH-2:0], in_i};

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        any_d      = any_q;
`ifdef DESER8_WAY_PARITY_EN
        par_d      = par_q;
`endif
        in_ready_o = 1'b0;

        case (state_q)
            COLLECT: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef DESER8_WAY_PARITY_EN
                        shreg_d = shifted;
                        state_d = PARITY;
`else
                        shreg_d = '0;
                        out_d   = shifted;
                        any_d   = |shifted;
                        state_d = HOLD;
`endif
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
`ifdef DESER8_WAY_PARITY_EN
            PARITY: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    out_d   = shreg_q;
                    any_d   = |shreg_q;
                    par_d   = (^shreg_q) ^ in_i;
                    shreg_d = '0;
                    state_d = HOLD;
                end
            end
`endif
            HOLD: begin
                in_ready_o = out_ready_i;
                if (out_ready_i) begin
                    any_d   = 1'b0;
`ifdef DESER8_WAY_PARITY_EN
                    par_d   = 1'b0;
`endif
                    state_d = COLLECT;
                    if (in_valid_i) begin
                        shreg_d = shifted;
                        cnt_d   = CW'(1);
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= COLLECT;
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            any_q   <= 1'b0;
`ifdef DESER8_WAY_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            any_q   <= any_d;
`ifdef DESER8_WAY_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = (state_q == HOLD);
    assign any_o       = any_q;
    assign cnt_o       = cnt_q;
`ifdef DESER8_WAY_PARITY_EN
    assign par_err_o   = par_q;
`endif

endmodule

// File: tb/tb_deser8_way.sv
// Directed bench for deser8_way: vector table for the main flows plus hand sequences
// for MSB-first ordering and (when DESER8_WAY_PARITY_EN is defined) the parity bit.
module tb_deser8_way;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, any;
    logic [7:0] out_w;
    logic [3:0] cnt;
    logic       in_ready_m, out_valid_m, any_m;
    logic [7:0] out_w_m;
    logic [3:0] cnt_m;
`ifdef DESER8_WAY_PARITY_EN
    logic       par_err, par_err_m;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    deser8_way #(.WIDTH(8), .LSB_FIRST(1)) dut (
        .clk_i(clk), .rst_i(rst), .in_i(in_bit), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .out_o(out_w), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .any_o(any),
`ifdef DESER8_WAY_PARITY_EN
        .par_err_o(par_err),
`endif
        .cnt_o(cnt)
    );

    deser8_way #(.WIDTH(8), .LSB_FIRST(0)) dut_m (
        .clk_i(clk), .rst_i(rst), .in_i(in_bit), .in_valid_i(in_valid),
        .in_ready_o(in_ready_m), .out_o(out_w_m), .out_valid_o(out_valid_m),
        .out_ready_i(out_ready), .any_o(any_m),
`ifdef DESER8_WAY_PARITY_EN
        .par_err_o(par_err_m),
`endif
        .cnt_o(cnt_m)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic       bit_v;
        logic       ordy;
        logic       exp_rdy;
        logic       exp_ovld;
        logic [7:0] exp_out;
        logic       exp_any;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vec_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; in_ready is sampled just after
    // that (pre-edge) and registered outputs 1 unit after the next edge.
    task automatic step(input logic r, input logic v, input logic b, input logic o,
                        output logic rdy);
        rst = r; in_valid = v; in_bit = b; out_ready = o;
        #1;
        rdy = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic v, input logic b, input logic o,
                       input logic e_rdy, input logic e_ovld, input logic [7:0] e_out,
                       input logic e_any, input logic [3:0] e_cnt);
        vec_t t;
        t.rst = r; t.vld = v; t.bit_v = b; t.ordy = o;
        t.exp_rdy = e_rdy; t.exp_ovld = e_ovld; t.exp_out = e_out;
        t.exp_any = e_any; t.exp_cnt = e_cnt;
        vec_q.push_back(t);
    endtask

    task automatic add_bits(input logic [7:0] bits_lsb_first, input logic o,
                            input logic [7:0] prev_out, input logic [7:0] word,
                            input int first_cnt);
        // Feeds bits of bits_lsb_first in index order starting at bit first_cnt.
        for (int k = first_cnt; k < 8; k++) begin
            if (k == 7) add(0, 1, bits_lsb_first[k], o, 1, 1, word, |word, 4'd0);
            else        add(0, 1, bits_lsb_first[k], o, 1, 0, prev_out, 0, 4'(k + 1));
        end
    endtask

    initial begin
        logic rdy;
        logic [7:0] seq;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifndef DESER8_WAY_PARITY_EN
        // Reset state, then 1,0,1,0,0,0,0,0 with consumer ready -> 8'h05 valid one cycle.
        add(1, 0, 0, 0, 1, 0, 8'h00, 0, 4'd0);
        add_bits(8'h05, 1, 8'h00, 8'h05, 0);
        add(0, 0, 0, 1, 1, 0, 8'h05, 0, 4'd0);
        // All-zero word held; extra bits back-pressured until out_ready.
        add_bits(8'h00, 0, 8'h05, 8'h00, 0);
        add(0, 1, 1, 0, 0, 1, 8'h00, 0, 4'd0);
        add(0, 1, 1, 0, 0, 1, 8'h00, 0, 4'd0);
        // Simultaneous word and bit accept -> cnt=1, valid drops.
        add(0, 1, 1, 1, 1, 0, 8'h00, 0, 4'd1);
        add(0, 1, 0, 1, 1, 0, 8'h00, 0, 4'd2);
        add(0, 1, 1, 1, 1, 0, 8'h00, 0, 4'd3);
        // Reset mid-word discards the partial word.
        add(1, 1, 1, 1, 1, 0, 8'h00, 0, 4'd0);
        // 8'hDF then back-pressure 5 cycles, then 8'hFF streamed with no bit lost.
        add_bits(8'hDF, 0, 8'h00, 8'hDF, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 1, 0, 0, 1, 8'hDF, 1, 4'd0);
        add(0, 1, 1, 1, 1, 0, 8'hDF, 0, 4'd1);
        add_bits(8'hFF, 0, 8'hDF, 8'hFF, 1);
        // Reset while holding a word.
        add(1, 0, 0, 0, 0, 0, 8'h00, 0, 4'd0);

        foreach (vec_q[i]) begin
            step(vec_q[i].rst, vec_q[i].vld, vec_q[i].bit_v, vec_q[i].ordy, rdy);
            chk($sformatf("v%0d_in_ready", i), 16'(rdy), 16'(vec_q[i].exp_rdy));
            chk($sformatf("v%0d_out_valid", i), 16'(out_valid), 16'(vec_q[i].exp_ovld));
            chk($sformatf("v%0d_out", i), 16'(out_w), 16'(vec_q[i].exp_out));
            chk($sformatf("v%0d_any", i), 16'(any), 16'(vec_q[i].exp_any));
            chk($sformatf("v%0d_cnt", i), 16'(cnt), 16'(vec_q[i].exp_cnt));
        end

        // MSB-first instance: 1,0,1,0,0,0,0,0 -> 8'hA0 (LSB-first instance sees 8'h05).
        seq = 8'h05;
        for (int k = 0; k < 8; k++) step(0, 1, seq[k], 0, rdy);
        chk("msb_out", 16'(out_w_m), 16'h00A0);
        chk("msb_valid", 16'(out_valid_m), 16'h0001);
        chk("msb_any", 16'(any_m), 16'h0001);
        chk("lsb_out_same_stream", 16'(out_w), 16'h0005);
        step(0, 0, 0, 1, rdy);
        chk("msb_consumed", 16'(out_valid_m), 16'h0000);
`else
        // Parity build: word 8'h01 with correct (1) then wrong (0) parity bit.
        step(1, 0, 0, 0, rdy);
        chk("par_reset_err", 16'(par_err), 16'h0000);
        chk("par_reset_valid", 16'(out_valid), 16'h0000);
        for (int p = 0; p < 2; p++) begin
            seq = 8'h01;
            for (int k = 0; k < 8; k++) step(0, 1, seq[k], 0, rdy);
            chk($sformatf("par%0d_wait_valid", p), 16'(out_valid), 16'h0000);
            chk($sformatf("par%0d_wait_cnt", p), 16'(cnt), 16'h0000);
            step(0, 1, (p == 0) ? 1'b1 : 1'b0, 0, rdy);
            chk($sformatf("par%0d_rdy", p), 16'(rdy), 16'h0001);
            chk($sformatf("par%0d_valid", p), 16'(out_valid), 16'h0001);
            chk($sformatf("par%0d_out", p), 16'(out_w), 16'h0001);
            chk($sformatf("par%0d_any", p), 16'(any), 16'h0001);
            chk($sformatf("par%0d_err", p), 16'(par_err), (p == 0) ? 16'h0000 : 16'h0001);
            chk($sformatf("par%0d_msb_out", p), 16'(out_w_m), 16'h0080);
            step(0, 0, 0, 1, rdy);
            chk($sformatf("par%0d_err_clr", p), 16'(par_err), 16'h0000);
            chk($sformatf("par%0d_valid_clr", p), 16'(out_valid), 16'h0000);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deser8_way.md
Name: deser8_way

Overview:
- Serial-to-parallel collector: the 1-to-8 counterpart of the 8-to-1 reduction gates.
- Accepts one bit per handshake, assembles an 8-bit word, presents it with a valid/ready handshake, and flags whether any assembled bit is set (any_o, an Or8Way of the word).
- Sits between a bit-serial source (shift chain, test stimulus) and 8-bit parallel logic in the gate/sequential library.

Parameters:
- WIDTH, 8, number of bits per word; legal values 2..16.
- LSB_FIRST, 1, 1 = first accepted bit lands in out_o[0]; 0 = first accepted bit lands in out_o[WIDTH-1].

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- in_i  input  1  serial data bit.
- in_valid_i  input  1  in_i is valid this cycle.
- in_ready_o  output  1  block accepts a bit this cycle.
- out_o  output  WIDTH  assembled word; stable while out_valid_o=1.
- out_valid_o  output  1  out_o holds a complete word.
- out_ready_i  input  1  consumer takes the word this cycle.
- any_o  output  1  OR-reduction of out_o; meaningful only while out_valid_o=1, otherwise 0.
- cnt_o  output  clog2(WIDTH+1)  number of bits collected in the current partial word.

Behaviour:
- Clock and reset: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset values (at the edge where rst_i=1): shift register 0, out_o=0, out_valid_o=0, any_o=0, cnt_o=0, state=COLLECT.
- Reset wins over every other event, including a reset arriving mid-word or while a word is held; the partial or held word is discarded.
- Bit accept: a bit is accepted when in_valid_i=1 and in_ready_o=1.
- Word accept: a word is taken when out_valid_o=1 and out_ready_i=1.
- in_ready_o = (state==COLLECT) or (state==HOLD and out_ready_i=1). This is combinational from state and out_ready_i only, never from in_valid_i.
- State COLLECT:
  - Each accepted bit is shifted in (per LSB_FIRST) and cnt_o increments.
  - If the accepted bit is the WIDTH-th, the next state is HOLD: out_o loads the complete word, out_valid_o goes to 1, any_o goes to |word, and cnt_o goes to 0.
  - Latency: out_valid_o rises on the clock edge that accepts the last bit, so it is visible the cycle after that bit is presented.
  - in_valid_i=0 leaves all state unchanged; there is no timeout.
- State HOLD:
  - out_o, out_valid_o and any_o are held stable until a word accept.
  - Word accept with no bit accept: next state is COLLECT and out_valid_o goes to 0; out_o keeps its last value and any_o goes to 0.
  - Word accept and bit accept in the same cycle: the word is consumed, the new bit becomes bit 0 of the next word (cnt_o=1), and the next state is COLLECT. This gives zero-bubble streaming.
  - No word accept: in_ready_o=0 and incoming bits are back-pressured, never dropped.
- Bit order:
  - LSB_FIRST=1: shift right, new bit enters at MSB. After WIDTH bits, the first bit is in out_o[0].
  - LSB_FIRST=0: shift left, new bit enters at LSB. After WIDTH bits, the first bit is in out_o[WIDTH-1].
- Counter: cnt_o ranges 0..WIDTH-1 in COLLECT and is 0 in HOLD. No wrap is possible beyond WIDTH.
- No combinational path from in_i to any output.

Optional Feature:
- Macro: DESER8_WAY_PARITY_EN.
- Defined:
  - Each word is followed by one extra serial bit carrying even parity over the WIDTH data bits.
  - The FSM gains state PARITY between COLLECT and HOLD. In PARITY, in_ready_o=1 and one accepted bit moves the FSM to HOLD.
  - Added output port par_err_o (1 bit): set with out_valid_o when the computed data parity XOR the received parity bit = 1; cleared on word accept and on reset.
  - out_valid_o rises on the edge that accepts the parity bit, not the last data bit.
- Undefined: no PARITY state, no par_err_o port; behaviour exactly as above.

Test Plan:
- Reset then stream: LSB_FIRST=1, bits 1,0,1,0,0,0,0,0 with in_valid_i=1 and out_ready_i=1 -> out_o=8'h05, out_valid_o=1 for exactly one cycle, any_o=1, cnt_o back to 0.
- All-zero word: 8 zero bits, out_ready_i=0 -> out_o=8'h00, any_o=0, out_valid_o held; a 9th bit presented is not accepted (in_ready_o=0) until out_ready_i=1.
- Back-pressure streaming: two words 8'hDF then 8'hFF, out_ready_i held low 5 cycles after the first -> first word stable 5 cycles; second word completes 8 accepts after release with no bit lost; any_o=1 both times.
- Simultaneous events: in HOLD, assert out_ready_i and in_valid_i together -> word consumed, cnt_o=1 next cycle, out_valid_o=0.
- Reset mid-operation: rst_i=1 after 3 bits (and separately while in HOLD) -> next cycle cnt_o=0, out_valid_o=0, out_o=0; a following 8-bit stream 8'hA0 with LSB_FIRST=0 yields out_o=8'hA0.
- With DESER8_WAY_PARITY_EN: word 8'h01 followed by parity bit 1 -> par_err_o=0; the same word followed by parity bit 0 -> par_err_o=1; both cleared on word accept.
